// File: rtl/fetch_queue.sv
// Instruction fetch: PC generation, one-cycle imem reads and a small decode-facing FIFO.
// Define FETCH_JAL_PRED_EN to predecode JAL responses and redirect fetch early.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rstn,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_pred
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = CW + 1;

    logic [31:0]   r_pc;
    logic [31:0]   r_inflight_pc;
    logic          r_inflight;
    logic          r_discard;
    logic [CW-1:0] r_count;
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [31:0]   r_buf_instr [DEPTH];
    logic [31:0]   r_buf_pc    [DEPTH];

    logic          w_deq;
    logic          w_enq;
    logic          w_pred;
    logic          w_issue;
    logic [OW-1:0] w_occ;
    logic [31:0]   w_target;

    assign out_valid = (r_count != '0);
    assign out_instr = r_buf_instr[r_rd_ptr];
    assign out_pc    = r_buf_pc[r_rd_ptr];

    assign w_deq = out_valid & out_ready;
    assign w_enq = r_inflight & ~r_discard & ~redirect_valid;

`ifdef FETCH_JAL_PRED_EN
    logic [31:0] w_imm;
    logic        r_buf_pred [DEPTH];

    // J-type immediate, sign-extended; target arithmetic wraps at 32 bits
    assign w_imm    = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                       imem_rdata[20], imem_rdata[30:21], 1'b0};
    assign w_target = r_inflight_pc + w_imm;
    assign w_pred   = w_enq & (imem_rdata[6:0] == 7'b1101111);
    assign out_pred = r_buf_pred[r_rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_buf_pred[i] <= 1'b0;
            end
        end else if (w_enq) begin
            r_buf_pred[r_wr_ptr] <= w_pred;
        end
    end
`else
    assign w_target = 32'h0000_0000;
    assign w_pred   = 1'b0;
    assign out_pred = 1'b0;
`endif

    // Every in-flight read holds a reserved FIFO slot, so enqueue can never overflow
    assign w_occ   = OW'(r_count) + OW'(r_inflight) - OW'(w_deq);
    assign w_issue = (w_occ < OW'(DEPTH)) & ~redirect_valid & ~w_pred;

    assign imem_en   = w_issue & rstn;
    assign imem_addr = r_pc;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= 32'h0000_0000;
            r_discard     <= 1'b0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_buf_instr[i] <= 32'h0000_0000;
                r_buf_pc[i]    <= 32'h0000_0000;
            end
        end else begin
            r_inflight <= w_issue;
            // Marks a response still owed after a flush; it lives for one response slot only
            r_discard  <= redirect_valid & r_inflight;
            if (w_issue) begin
                r_inflight_pc <= r_pc;
            end
            if (redirect_valid) begin
                r_pc     <= {redirect_pc[31:2], 2'b00};
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                if (w_pred) begin
                    r_pc <= {w_target[31:2], 2'b00};
                end else if (w_issue) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_enq) begin
                    r_buf_instr[r_wr_ptr] <= imem_rdata;
                    r_buf_pc[r_wr_ptr]    <= r_inflight_pc;
                    r_wr_ptr              <= r_wr_ptr + AW'(1);
                end
                if (w_deq) begin
                    r_rd_ptr <= r_rd_ptr + AW'(1);
                end
                r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            end
        end
    end

endmodule
